// File: rtl/solo_squash_wb_regs.sv
// solo_squash_wb_regs: Wishbone classic register block for solo_squash.
// Lets the management SoC override game inputs, start a new game, read
// the live status byte and count vsync frames.
// Optional build macro: SOLO_SQUASH_WB_IRQ_EN adds a sticky frame interrupt
// with an enable bit at CTRL[16] and a W1C flag at CTRL[24].
module solo_squash_wb_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        game_vsync_i,
  input  logic [7:0]  game_status_i,
  output logic        ctrl_override_o,
  output logic        ctrl_up_o,
  output logic        ctrl_down_o,
  output logic        ctrl_pause_o,
  output logic        new_game_o,
  output logic        irq_o
);

  localparam logic [31:0] ID_WORD    = 32'h5351_5348;
  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_STATUS = 2'd1;
  localparam logic [1:0]  REG_FRAMES = 2'd2;
  localparam logic [1:0]  REG_ID     = 2'd3;
  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1'b1);

  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;
  logic [3:0]             ctrl_q, ctrl_d;   // [0] override [1] up [2] down [3] pause
  logic                   new_game_q, new_game_d;
  logic                   vsync_q, vsync_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;

  logic                   hit, xfer, wr_ctrl, wr_frames, rise;
  logic [1:0]             reg_sel;
  logic [31:0]            frame_word, ctrl_word, rd_word;
  logic                   unused_bits;

`ifdef SOLO_SQUASH_WB_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_flag_q, irq_flag_d;
  logic irq_q, irq_d;
`endif

  // Bus decode: a transfer happens on the edge that raises ack, so a held strobe re-acks every other cycle
  always_comb begin
    hit         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    xfer        = hit & ~ack_q;
    reg_sel     = wbs_adr_i[3:2];
    wr_ctrl     = xfer & wbs_we_i & (reg_sel == REG_CTRL);
    wr_frames   = xfer & wbs_we_i & (reg_sel == REG_FRAMES);
    rise        = game_vsync_i & ~vsync_q;
    unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};
  end

  // Read mux: assemble each register word, zero-extending the frame counter
  always_comb begin
    frame_word                   = 32'h0000_0000;
    frame_word[FRAME_CNT_W-1:0]  = frame_q;
    ctrl_word                    = 32'h0000_0000;
    ctrl_word[3:0]               = ctrl_q;
`ifdef SOLO_SQUASH_WB_IRQ_EN
    ctrl_word[16]                = irq_en_q;
    ctrl_word[24]                = irq_flag_q;
`endif
    case (reg_sel)
      REG_CTRL:   rd_word = ctrl_word;
      REG_STATUS: rd_word = {24'h00_0000, game_status_i};
      REG_FRAMES: rd_word = frame_word;
      REG_ID:     rd_word = ID_WORD;
      default:    rd_word = 32'h0000_0000;
    endcase
  end

  // Next-state for bus response, control bits, new-game pulse and frame counter
  always_comb begin
    ack_d      = xfer;
    vsync_d    = game_vsync_i;
    new_game_d = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[8];
    if (xfer && !wbs_we_i) begin
      dat_d = rd_word;
    end else begin
      dat_d = 32'h0000_0000;
    end
    if (wr_ctrl && wbs_sel_i[0]) begin
      ctrl_d = wbs_dat_i[3:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    // A clearing write beats a coincident vsync rise; that edge is dropped
    if (wr_frames && (wbs_sel_i != 4'b0000)) begin
      frame_d = '0;
    end else if (rise) begin
      frame_d = frame_q + FRAME_ONE;
    end else begin
      frame_d = frame_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0000_0000;
      ctrl_q     <= 4'h0;
      new_game_q <= 1'b0;
      vsync_q    <= 1'b0;
      frame_q    <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      ctrl_q     <= ctrl_d;
      new_game_q <= new_game_d;
      vsync_q    <= vsync_d;
      frame_q    <= frame_d;
    end
  end

`ifdef SOLO_SQUASH_WB_IRQ_EN
  // Interrupt next-state: sticky flag where a new rise beats a W1C in the same cycle
  always_comb begin
    if (wr_ctrl && wbs_sel_i[2]) begin
      irq_en_d = wbs_dat_i[16];
    end else begin
      irq_en_d = irq_en_q;
    end
    if (rise) begin
      irq_flag_d = 1'b1;
    end else if (wr_ctrl && wbs_sel_i[3] && wbs_dat_i[24]) begin
      irq_flag_d = 1'b0;
    end else begin
      irq_flag_d = irq_flag_q;
    end
    irq_d = irq_flag_d & irq_en_d;
  end

  // Interrupt registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o       = ack_q;
  assign wbs_dat_o       = dat_q;
  assign ctrl_override_o = ctrl_q[0];
  assign ctrl_up_o       = ctrl_q[1];
  assign ctrl_down_o     = ctrl_q[2];
  assign ctrl_pause_o    = ctrl_q[3];
  assign new_game_o      = new_game_q;

endmodule

// File: tb/tb_solo_squash_wb_regs.sv
// Bench for solo_squash_wb_regs: two instances (16-bit and 4-bit frame
// counters) share one bus; a cycle-level model of the register map is
// compared against both on every falling edge, and directed reads are
// also checked against hand-computed literals.
module tb_solo_squash_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h5351_5348;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, vsync;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic [7:0]  status;

  logic        ack16, ov16, up16, dn16, pa16, ng16, irq16;
  logic        ack4, ov4, up4, dn4, pa4, ng4, irq4;
  logic [31:0] dat16, dat4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  solo_squash_wb_regs u_dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack16), .wbs_dat_o(dat16),
    .game_vsync_i(vsync), .game_status_i(status), .ctrl_override_o(ov16), .ctrl_up_o(up16),
    .ctrl_down_o(dn16), .ctrl_pause_o(pa16), .new_game_o(ng16), .irq_o(irq16)
  );

  solo_squash_wb_regs #(.FRAME_CNT_W(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack4), .wbs_dat_o(dat4),
    .game_vsync_i(vsync), .game_status_i(status), .ctrl_override_o(ov4), .ctrl_up_o(up4),
    .ctrl_down_o(dn4), .ctrl_pause_o(pa4), .new_game_o(ng4), .irq_o(irq4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_started = 1'b0;
  logic        m_ack, m_ng, m_vs_prev, m_en, m_flag;
  logic [3:0]  m_ctrl;
  logic [31:0] m_frames, m_dat16, m_dat4;

  wire       m_go   = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
  wire [1:0] m_reg  = adr[3:2];
  wire       m_rise = vsync && !m_vs_prev;

  function automatic logic [31:0] model_read(input logic [1:0] r, input int w);
    logic [31:0] v;
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (r)
      2'd0: begin
        v = {28'h0, m_ctrl};
`ifdef SOLO_SQUASH_WB_IRQ_EN
        v[16] = m_en;
        v[24] = m_flag;
`endif
      end
      2'd1:    v = {24'h0, status};
      2'd2:    v = m_frames & mask;
      default: v = ID;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_ack <= 1'b0; m_ng <= 1'b0; m_vs_prev <= 1'b0; m_en <= 1'b0; m_flag <= 1'b0;
      m_ctrl <= 4'h0; m_frames <= 32'h0; m_dat16 <= 32'h0; m_dat4 <= 32'h0;
    end else begin
      m_ack     <= m_go;
      m_vs_prev <= vsync;
      m_dat16   <= (m_go && !we) ? model_read(m_reg, 16) : 32'h0;
      m_dat4    <= (m_go && !we) ? model_read(m_reg, 4) : 32'h0;
      m_ng      <= m_go && we && m_reg == 2'd0 && sel[1] && dat_w[8];
      if (m_go && we && m_reg == 2'd0 && sel[0]) m_ctrl <= dat_w[3:0];
      if (m_go && we && m_reg == 2'd2 && sel != 4'b0000) m_frames <= 32'h0;
      else if (m_rise) m_frames <= m_frames + 32'd1;
      if (m_go && we && m_reg == 2'd0 && sel[2]) m_en <= dat_w[16];
      if (m_rise) m_flag <= 1'b1;
      else if (m_go && we && m_reg == 2'd0 && sel[3] && dat_w[24]) m_flag <= 1'b0;
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (m_started) begin
      check("ack16", ack16, m_ack);
      check("ack4", ack4, m_ack);
      check("dat16", dat16, m_dat16);
      check("dat4", dat4, m_dat4);
      check("ctrl16", {pa16, dn16, up16, ov16}, m_ctrl);
      check("ctrl4", {pa4, dn4, up4, ov4}, m_ctrl);
      check("newgame16", ng16, m_ng);
      check("newgame4", ng4, m_ng);
`ifdef SOLO_SQUASH_WB_IRQ_EN
      check("irq16", irq16, m_flag & m_en);
      check("irq4", irq4, m_flag & m_en);
`else
      check("irq16", irq16, 1'b0);
      check("irq4", irq4, 1'b0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r16, output logic [31:0] r4,
                          output logic ng);
    int lat;
    lat = -1; r16 = 32'h0; r4 = 32'h0; ng = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack16) begin
        lat = i; r16 = dat16; r4 = dat4; ng = ng16;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_latency", lat, 32'd0);
  endtask

  task automatic pulse_vsync(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r16, r4;
    logic        ng;
    logic [3:0]  pat;
    int          seen;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; vsync = 1'b0; status = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ack", ack16, 1'b0);
    check("rst_dat", dat16, 32'h0);
    check("rst_ctrl", {pa16, dn16, up16, ov16}, 4'h0);
    check("rst_newgame", ng16, 1'b0);
    check("rst_irq", irq16, 1'b0);
    rst = 1'b0;

    // ID register
    bus_xfer(1'b0, BASE + 32'hC, 32'h0, 4'hF, r16, r4, ng);
    check("id16", r16, ID);
    check("id4", r4, ID);

    // CTRL byte 0
    bus_xfer(1'b1, BASE, 32'h0000_000F, 4'b0001, r16, r4, ng);
    check("ctrl_out", {pa16, dn16, up16, ov16}, 4'hF);
    bus_xfer(1'b0, BASE + 32'h2, 32'h0, 4'hF, r16, r4, ng);  // low address bits ignored
    check("ctrl_rd", r16, 32'h0000_000F);

    // new-game pulse, byte 1 only
    bus_xfer(1'b1, BASE, 32'h0000_0100, 4'b0010, r16, r4, ng);
    check("newgame_pulse", ng, 1'b1);
    @(negedge clk);
    check("newgame_drop", ng16, 1'b0);
    bus_xfer(1'b0, BASE, 32'h0, 4'hF, r16, r4, ng);
    check("ctrl_after_ng", r16, 32'h0000_000F);

    // sel=0 write changes nothing
    bus_xfer(1'b1, BASE, 32'h0000_0100, 4'b0000, r16, r4, ng);
    check("sel0_no_ng", ng, 1'b0);
    check("sel0_ctrl", {pa16, dn16, up16, ov16}, 4'hF);

    // STATUS and read-only writes
    status = 8'hA5;
    bus_xfer(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, r16, r4, ng);
    bus_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, r16, r4, ng);
    check("status_rd", r16, 32'h0000_00A5);
    bus_xfer(1'b1, BASE + 32'hC, 32'h0, 4'hF, r16, r4, ng);
    bus_xfer(1'b0, BASE + 32'hC, 32'h0, 4'hF, r16, r4, ng);
    check("id_ro", r16, ID);

    // frame counter
    pulse_vsync(5);
    bus_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r16, r4, ng);
    check("frames5_16", r16, 32'd5);
    check("frames5_4", r4, 32'd5);
    pulse_vsync(12);
    bus_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r16, r4, ng);
    check("frames17_16", r16, 32'd17);
    check("frames17_4", r4, 32'd1);
    pulse_vsync(2);
    bus_xfer(1'b1, BASE + 32'h8, 32'h0, 4'b0000, r16, r4, ng);  // sel=0 does not clear
    bus_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r16, r4, ng);
    check("frames19_16", r16, 32'd19);
    check("frames19_4", r4, 32'd3);
    // clear write coinciding with a vsync rise: write wins
    @(negedge clk);
    vsync = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h8; sel = 4'b0100; dat_w = 32'h0;
    @(negedge clk);
    check("clr_ack", ack16, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; vsync = 1'b0;
    bus_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r16, r4, ng);
    check("clr_rise_16", r16, 32'd0);
    check("clr_rise_4", r4, 32'd0);
    pulse_vsync(1);
    bus_xfer(1'b0, BASE + 32'h8, 32'h0, 4'hF, r16, r4, ng);
    check("after_clr", r16, 32'd1);

    // outside window, and cyc low: never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    seen = 0;
    repeat (16) begin @(negedge clk); if (ack16 || ack4) seen++; end
    check("oow_noack", seen, 32'd0);
    cyc = 1'b0; adr = BASE + 32'hC;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ack16 || ack4) seen++; end
    check("nocyc_noack", seen, 32'd0);
    stb = 1'b0;

    // held strobe: ack every other cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'hC;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = ack16; end
    check("held_pattern", pat, 4'b0101);
    cyc = 1'b0; stb = 1'b0;

`ifdef SOLO_SQUASH_WB_IRQ_EN
    bus_xfer(1'b1, BASE, 32'h0100_0000, 4'b1000, r16, r4, ng);  // clear flag from earlier frames
    bus_xfer(1'b1, BASE, 32'h0001_0000, 4'b0100, r16, r4, ng);
    check("irq_idle", irq16, 1'b0);
    pulse_vsync(1);
    check("irq_set", irq16, 1'b1);
    bus_xfer(1'b0, BASE, 32'h0, 4'hF, r16, r4, ng);
    check("ctrl_irq_rd", r16, 32'h0101_000F);
    bus_xfer(1'b1, BASE, 32'h0100_0000, 4'b1000, r16, r4, ng);
    check("irq_w1c", irq16, 1'b0);
    @(negedge clk);
    vsync = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'b1000; dat_w = 32'h0100_0000;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; vsync = 1'b0;
    check("irq_set_wins", irq16, 1'b1);
`else
    pulse_vsync(2);
    check("irq_tied", irq16, 1'b0);
    bus_xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'hF, r16, r4, ng);
    bus_xfer(1'b0, BASE, 32'h0, 4'hF, r16, r4, ng);
    check("ctrl_hi_zero", r16, 32'h0000_000F);
`endif

    // reset landing on the hit edge: no ack, write lost
    @(negedge clk);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'h1; dat_w = 32'h0000_0005;
    @(negedge clk);
    check("rst_mid_ack", ack16, 1'b0);
    check("rst_mid_ctrl", {pa16, dn16, up16, ov16}, 4'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_xfer(1'b0, BASE, 32'h0, 4'hF, r16, r4, ng);
    check("ctrl_after_rst", r16, 32'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
